// File: rtl/pipe_trace_buffer_pkg.sv
// Shared definitions for the retirement-trace capture buffer: FSM state
// encodings and the packed entry-word geometry.
package pipe_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int INST_W = 32;
  localparam int RD_W   = 5;

  // One stored entry is {pc, inst, rd, we, wd}.
  function automatic int entry_width(input int pc_w, input int data_w);
    return pc_w + INST_W + RD_W + 1 + data_w;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// Retirement input stream and oldest-first readout port of the trace buffer.
// The core/bench side uses the master modport, the buffer uses slave.
interface pipe_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);

  logic              RET_VALID;
  logic [PC_W-1:0]   RET_PC;
  logic [31:0]       RET_INST;
  logic [4:0]        RET_RD;
  logic              RET_WE;
  logic [DATA_W-1:0] RET_WD;

  logic              RD_VALID;
  logic              RD_READY;
  logic [PC_W-1:0]   RD_PC;
  logic [31:0]       RD_INST;
  logic [4:0]        RD_RD;
  logic              RD_WE;
  logic [DATA_W-1:0] RD_WD;

  modport master (
    output RET_VALID, RET_PC, RET_INST, RET_RD, RET_WE, RET_WD, RD_READY,
    input  RD_VALID, RD_PC, RD_INST, RD_RD, RD_WE, RD_WD
  );

  modport slave (
    input  RET_VALID, RET_PC, RET_INST, RET_RD, RET_WE, RET_WD, RD_READY,
    output RD_VALID, RD_PC, RD_INST, RD_RD, RD_WE, RD_WD
  );

endinterface

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Trace storage: DEPTH x W array, synchronous write, asynchronous read.
// Contents are not reset; the controller masks them while empty.
module pipe_trace_buffer_trace_ram #(
  parameter int DEPTH = 64,
  parameter int W     = 102
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Capture one retirement entry per enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Retirement-trace capture buffer: records write-back events into a circular
// buffer until trigger/PC-match/full/freeze, then drains oldest-first.
module pipe_trace_buffer
  import pipe_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32,
  parameter int POST_TRIG = 16,
  parameter int STOP_FULL = 0
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   CAP_EN,
  input  logic                   CLR,
  input  logic                   TRIG,
  input  logic                   TRIG_PC_EN,
  input  logic [PC_W-1:0]        TRIG_PC,
  pipe_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVERFLOW,
  output logic [1:0]             STATE
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_width(PC_W, DATA_W);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PT_INIT  = PTR_W'(POST_TRIG);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  state_t             r_state;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic [PTR_W-1:0]   r_post_cnt;

  state_t             w_state_nxt;
  logic [PTR_W-1:0]   w_wr_ptr_nxt;
  logic [PTR_W-1:0]   w_rd_ptr_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               w_overflow_nxt;
  logic [PTR_W-1:0]   w_post_cnt_nxt;

  logic               w_capturing;
  logic               w_wr;
  logic               w_full;
  logic               w_trig;
  logic               w_rd_valid;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  logic [PC_W-1:0]    w_rd_pc;
  logic [31:0]        w_rd_inst;
  logic [4:0]         w_rd_rd;
  logic               w_rd_we;
  logic [DATA_W-1:0]  w_rd_wd;

  // A freeze (CAP_EN low) or clear in the same cycle suppresses the write.
  assign w_capturing = (r_state == ST_CAPTURE) || (r_state == ST_POST);
  assign w_wr        = w_capturing && CAP_EN && bus.RET_VALID && !CLR;
  assign w_full      = (r_count == CNT_FULL);
  assign w_trig      = TRIG || (TRIG_PC_EN && bus.RET_VALID && (bus.RET_PC == TRIG_PC));
  assign w_rd_valid  = (r_state == ST_DONE) && (r_count != '0);
  assign w_pop       = w_rd_valid && bus.RD_READY;

  assign w_wdata = {bus.RET_PC, bus.RET_INST, bus.RET_RD, bus.RET_WE, bus.RET_WD};

  pipe_trace_buffer_trace_ram #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_trace_ram (
    .i_clk   (CLK),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign {w_rd_pc, w_rd_inst, w_rd_rd, w_rd_we, w_rd_wd} = w_rdata;

  // Readout fields are masked to zero whenever no entry is being offered.
  assign bus.RD_VALID = w_rd_valid;
  assign bus.RD_PC    = w_rd_valid ? w_rd_pc   : '0;
  assign bus.RD_INST  = w_rd_valid ? w_rd_inst : '0;
  assign bus.RD_RD    = w_rd_valid ? w_rd_rd   : '0;
  assign bus.RD_WE    = w_rd_valid ? w_rd_we   : 1'b0;
  assign bus.RD_WD    = w_rd_valid ? w_rd_wd   : '0;

  assign COUNT    = r_count;
  assign OVERFLOW = r_overflow;
  assign STATE    = r_state;

  // Next-state, pointer, count and trigger countdown logic; CLR wins over all.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_post_cnt_nxt = r_post_cnt;
    if (CLR) begin
      w_state_nxt    = ST_IDLE;
      w_wr_ptr_nxt   = '0;
      w_rd_ptr_nxt   = '0;
      w_count_nxt    = '0;
      w_overflow_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (CAP_EN) begin
            w_state_nxt    = ST_CAPTURE;
            w_wr_ptr_nxt   = '0;
            w_rd_ptr_nxt   = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
          end
        end
        ST_CAPTURE, ST_POST: begin
          if (!CAP_EN) begin
            w_state_nxt = ST_DONE;
          end else begin
            if (w_wr) begin
              w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
              if (w_full) begin
                // Wrapping: the oldest entry is overwritten.
                w_rd_ptr_nxt   = r_rd_ptr + PTR_ONE;
                w_overflow_nxt = 1'b1;
              end else begin
                w_count_nxt = r_count + CNT_ONE;
              end
            end
            if (r_state == ST_CAPTURE) begin
              if (w_trig) begin
                if (POST_TRIG == 0) begin
                  w_state_nxt = ST_DONE;
                end else begin
                  w_state_nxt    = ST_POST;
                  w_post_cnt_nxt = PT_INIT;
                end
              end
            end else if (w_wr) begin
              w_post_cnt_nxt = r_post_cnt - PTR_ONE;
              if (r_post_cnt == PTR_ONE) begin
                w_state_nxt = ST_DONE;
              end
            end
            if ((STOP_FULL != 0) && w_wr && (r_count == CNT_LAST)) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
            w_count_nxt  = r_count - CNT_ONE;
            if (r_count == CNT_ONE) begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control state register; asynchronous reset aborts any capture or drain.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_post_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
      r_post_cnt <= w_post_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Scoreboard bench for pipe_trace_buffer (DEPTH=8, POST_TRIG=2). dut0 wraps
// when full, dut1 freezes when full. Expected drain entries are queued by the
// stimulus; a monitor pops and compares on each accepted readout of dut0.
module tb_pipe_trace_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] wd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cap_en0 = 1'b0, clr0 = 1'b0, rd_ready0 = 1'b0;
  logic        cap_en1 = 1'b0, clr1 = 1'b0, rd_ready1 = 1'b0;
  logic        trig = 1'b0, trig_pc_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_pc = '0, ret_inst = '0, ret_wd = '0;
  logic [4:0]  ret_rd = '0;
  logic        ret_we = 1'b0;

  logic [3:0]  count0, count1;
  logic        ovf0, ovf1;
  logic [1:0]  state0, state1;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t sb_q[$];
  ent_t got_e, exp_e;

  always #5 clk = ~clk;

  pipe_trace_buffer_if #(.PC_W(32), .DATA_W(32)) bus0 ();
  pipe_trace_buffer_if #(.PC_W(32), .DATA_W(32)) bus1 ();

  assign bus0.RET_VALID = ret_valid;
  assign bus0.RET_PC    = ret_pc;
  assign bus0.RET_INST  = ret_inst;
  assign bus0.RET_RD    = ret_rd;
  assign bus0.RET_WE    = ret_we;
  assign bus0.RET_WD    = ret_wd;
  assign bus0.RD_READY  = rd_ready0;
  assign bus1.RET_VALID = ret_valid;
  assign bus1.RET_PC    = ret_pc;
  assign bus1.RET_INST  = ret_inst;
  assign bus1.RET_RD    = ret_rd;
  assign bus1.RET_WE    = ret_we;
  assign bus1.RET_WD    = ret_wd;
  assign bus1.RD_READY  = rd_ready1;

  pipe_trace_buffer #(.DEPTH(8), .PC_W(32), .DATA_W(32), .POST_TRIG(2), .STOP_FULL(0)) dut0 (
    .CLK(clk), .RSTn(rst_n), .CAP_EN(cap_en0), .CLR(clr0), .TRIG(trig),
    .TRIG_PC_EN(trig_pc_en), .TRIG_PC(trig_pc), .bus(bus0.slave),
    .COUNT(count0), .OVERFLOW(ovf0), .STATE(state0)
  );

  pipe_trace_buffer #(.DEPTH(8), .PC_W(32), .DATA_W(32), .POST_TRIG(2), .STOP_FULL(1)) dut1 (
    .CLK(clk), .RSTn(rst_n), .CAP_EN(cap_en1), .CLR(clr1), .TRIG(trig),
    .TRIG_PC_EN(trig_pc_en), .TRIG_PC(trig_pc), .bus(bus1.slave),
    .COUNT(count1), .OVERFLOW(ovf1), .STATE(state1)
  );

  // Entry payload derived from the PC so each drained word is distinguishable.
  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc   = pc;
    e.inst = pc ^ 32'hA5A5_0000;
    e.rd   = pc[6:2];
    e.we   = pc[2];
    e.wd   = pc * 3 + 32'd1;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] pc, input logic t);
    ent_t e;
    e = mk(pc);
    ret_valid = 1'b1; ret_pc = e.pc; ret_inst = e.inst;
    ret_rd = e.rd; ret_we = e.we; ret_wd = e.wd; trig = t;
    tick();
    ret_valid = 1'b0; trig = 1'b0;
  endtask

  // Drain dut0 until it returns to IDLE, bounded by a cycle budget.
  task automatic drain0(input int budget);
    bit done;
    done = 1'b0;
    rd_ready0 = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (state0 == 2'd0) done = 1'b1;
    end
    rd_ready0 = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: state %0d after %0d cycles, required 0", state0, budget);
    end
    check("drain_sb_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: compares every entry accepted from dut0's readout.
  always @(negedge clk) begin
    if (rst_n && bus0.RD_VALID && rd_ready0 && !clr0) begin
      got_e = '{bus0.RD_PC, bus0.RD_INST, bus0.RD_RD, bus0.RD_WE, bus0.RD_WD};
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got pc 0x%0h, required no entry", got_e.pc);
      end else begin
        exp_e = sb_q.pop_front();
        if (got_e !== exp_e) begin
          n_fail++;
          $display("FAIL pop_entry: got pc 0x%0h wd 0x%0h, required pc 0x%0h wd 0x%0h",
                   got_e.pc, got_e.wd, exp_e.pc, exp_e.wd);
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    check("rst_state", 64'(state0), 64'd0);
    check("rst_count", 64'(count0), 64'd0);
    check("rst_ovf", 64'(ovf0), 64'd0);
    check("rst_rd_valid", 64'(bus0.RD_VALID), 64'd0);
    check("rst_rd_pc", 64'(bus0.RD_PC), 64'd0);
    rst_n = 1'b1;
    tick();

    // Wrap with overflow: 11 writes into 8 entries.
    cap_en0 = 1'b1;
    tick();
    check("s1_capture", 64'(state0), 64'd1);
    for (int i = 0; i < 11; i++) wr(32'h100 + 32'(4 * i), 1'b0);
    cap_en0 = 1'b0;
    tick();
    check("s1_state", 64'(state0), 64'd3);
    check("s1_count", 64'(count0), 64'd8);
    check("s1_ovf", 64'(ovf0), 64'd1);
    check("s1_rd_valid", 64'(bus0.RD_VALID), 64'd1);
    for (int i = 3; i < 11; i++) sb_q.push_back(mk(32'h100 + 32'(4 * i)));
    drain0(20);
    check("s1_idle_ovf_kept", 64'(ovf0), 64'd1);

    // External trigger on the 3rd write, POST_TRIG=2.
    cap_en0 = 1'b1;
    tick();
    check("s2_ovf_cleared", 64'(ovf0), 64'd0);
    for (int i = 0; i < 8; i++) begin
      wr(32'h300 + 32'(4 * i), i == 2);
      if (i == 3) check("s2_post", 64'(state0), 64'd2);
      if (i == 4) check("s2_done_at_5", 64'(state0), 64'd3);
    end
    check("s2_count", 64'(count0), 64'd5);
    check("s2_ovf", 64'(ovf0), 64'd0);
    cap_en0 = 1'b0;
    for (int i = 0; i < 5; i++) sb_q.push_back(mk(32'h300 + 32'(4 * i)));
    drain0(20);

    // PC-match trigger with idle retirement gaps; CAP_EN held through drain.
    trig_pc_en = 1'b1; trig_pc = 32'h200;
    cap_en0 = 1'b1;
    tick();
    wr(32'h1F8, 1'b0); tick();
    wr(32'h1FC, 1'b0); tick(); tick();
    wr(32'h200, 1'b0);
    check("s3_post", 64'(state0), 64'd2);
    tick();
    wr(32'h204, 1'b0);
    check("s3_still_post", 64'(state0), 64'd2);
    tick();
    wr(32'h208, 1'b0);
    check("s3_done", 64'(state0), 64'd3);
    check("s3_count", 64'(count0), 64'd5);
    foreach (sb_q[i]) sb_q.delete(i);
    sb_q.push_back(mk(32'h1F8)); sb_q.push_back(mk(32'h1FC));
    sb_q.push_back(mk(32'h200)); sb_q.push_back(mk(32'h204));
    sb_q.push_back(mk(32'h208));
    drain0(20);
    cap_en0 = 1'b0; trig_pc_en = 1'b0;
    tick();
    check("s3_idle_hold", 64'(state0), 64'd0);

    // Freeze-when-full on dut1, then backpressure.
    cap_en1 = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      wr(32'h500 + 32'(4 * i), 1'b0);
      if (i == 6) check("s4_not_done_7", 64'(state1), 64'd1);
    end
    check("s4_done", 64'(state1), 64'd3);
    check("s4_count", 64'(count1), 64'd8);
    check("s4_ovf", 64'(ovf1), 64'd0);
    cap_en1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s4_hold_valid", 64'(bus1.RD_VALID), 64'd1);
      check("s4_hold_pc", 64'(bus1.RD_PC), 64'h500);
    end
    rd_ready1 = 1'b1;
    tick();
    rd_ready1 = 1'b0;
    check("s4_pop_pc", 64'(bus1.RD_PC), 64'h504);
    check("s4_pop_count", 64'(count1), 64'd7);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    check("s4_clr", 64'(state1), 64'd0);

    // CLR together with RD_READY mid-drain.
    cap_en0 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) wr(32'h400 + 32'(4 * i), 1'b0);
    cap_en0 = 1'b0;
    tick();
    check("s5_count", 64'(count0), 64'd4);
    sb_q.push_back(mk(32'h400)); sb_q.push_back(mk(32'h404));
    rd_ready0 = 1'b1;
    tick(); tick();
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0; rd_ready0 = 1'b0;
    check("s5_state", 64'(state0), 64'd0);
    check("s5_count0", 64'(count0), 64'd0);
    check("s5_rd_valid", 64'(bus0.RD_VALID), 64'd0);
    check("s5_sb_empty", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset in POST.
    cap_en0 = 1'b1;
    tick();
    wr(32'h600, 1'b1);
    wr(32'h604, 1'b0);
    check("s6_post", 64'(state0), 64'd2);
    check("s6_count_pre", 64'(count0), 64'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_rst_state", 64'(state0), 64'd0);
    check("s6_rst_count", 64'(count0), 64'd0);
    check("s6_rst_ovf", 64'(ovf0), 64'd0);
    check("s6_rst_rd_valid", 64'(bus0.RD_VALID), 64'd0);
    check("s6_rst_rd_pc", 64'(bus0.RD_PC), 64'd0);
    cap_en0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Synthesizable retirement-trace capture buffer for the RISCV_TOP pipeline; it replaces per-cycle `$display` dumps of MEM/WB state. It sits beside the core and records every write-back event (PC, instruction, destination, data) into a circular buffer. Recording stops on a trigger, an optional PC match, a full buffer or a manual freeze. The frozen trace is then drained oldest-first over a valid/ready port to a bench monitor or debug bridge.

## Interface
Parameters:
- DEPTH, 64, number of entries; power of two, at least 4
- PC_W, 32, PC width
- DATA_W, 32, write-back data width
- POST_TRIG, 16, entries captured after the trigger entry; range 0..DEPTH-1
- STOP_FULL, 0, 0 = wrap and overwrite oldest; 1 = freeze when full

Ports:
- CLK  in  1  core clock
- RSTn  in  1  asynchronous active-low reset
- CAP_EN  in  1  arm/keep capturing; deassertion freezes
- CLR  in  1  synchronous clear; returns to IDLE
- TRIG  in  1  external trigger pulse
- TRIG_PC_EN  in  1  enable PC-match trigger
- TRIG_PC  in  PC_W  PC-match value
- RET_VALID  in  1  retirement event this cycle
- RET_PC  in  PC_W  retired PC
- RET_INST  in  32  retired instruction
- RET_RD  in  5  destination register
- RET_WE  in  1  register write enable
- RET_WD  in  DATA_W  write-back data
- RD_VALID  out  1  readout entry available
- RD_READY  in  1  consumer accepts entry
- RD_PC / RD_INST / RD_RD / RD_WE / RD_WD  out  PC_W/32/5/1/DATA_W  oldest entry fields
- COUNT  out  $clog2(DEPTH)+1  valid entries held
- OVERFLOW  out  1  sticky; an entry was overwritten
- STATE  out  2  IDLE=0, CAPTURE=1, POST=2, DONE=3

## Operation
- IDLE: nothing written. CAP_EN=1 moves to CAPTURE with pointers and COUNT at 0 and OVERFLOW cleared.
- CAPTURE: each RET_VALID writes an entry at wr_ptr and increments wr_ptr (mod DEPTH).
  - COUNT saturates at DEPTH.
  - Full with STOP_FULL=0: rd_ptr advances with the write and OVERFLOW is set.
  - STOP_FULL=1: the write that makes COUNT=DEPTH also moves to DONE.
- Trigger condition: TRIG=1, or TRIG_PC_EN=1 with RET_VALID=1 and RET_PC==TRIG_PC.
  - The entry written in the trigger cycle, if any, is the trigger entry.
  - POST_TRIG=0: go straight to DONE.
  - Otherwise go to POST with post_cnt=POST_TRIG.
- POST: each write decrements post_cnt. The write that brings it to 0 moves to DONE. Overwrite and OVERFLOW rules are the same as in CAPTURE.
- CAP_EN=0 in CAPTURE or POST moves to DONE. A RET_VALID in that same cycle is not written.
- DONE: no writes.
  - RD_VALID = (COUNT != 0). RD_* reflect mem[rd_ptr] combinationally.
  - RD_VALID && RD_READY pops one entry: rd_ptr++, COUNT--.
  - A pop that makes COUNT=0 moves to IDLE, even if CAP_EN is held.
- CLR has priority over every other event, including a pop or trigger in the same cycle. It goes to IDLE, zeroes pointers and COUNT, and clears OVERFLOW.
- Reset: STATE=IDLE, COUNT=0, OVERFLOW=0, RD_VALID=0, RD_* = 0 (memory contents are don't-care and are masked while COUNT=0).

## Timing
- A write on edge N is reflected in COUNT after edge N and is readable in DONE from the following cycle.
- RD_* change only on a pop edge. The readout latency is zero (first-word-fall-through).
- Trigger-to-DONE takes exactly POST_TRIG further RET_VALID cycles. Idle retirement cycles do not count.
- Asynchronous reset mid-drain aborts the drain immediately. No partial state survives.
- Sustained throughput is one capture per cycle and one pop per cycle.

## Structure
- Shared package: STATE encodings, and the entry-word width expression PC_W+32+5+1+DATA_W.
- Sub-module trace_ram: a DEPTH×entry-word array with a synchronous write port and an asynchronous read port, and no reset.
- The FSM, pointers, counters and trigger logic live in the top module.

## Test plan
All scenarios use DEPTH=8, POST_TRIG=2.
- STOP_FULL=0: write 11 entries with PC=0x100, 0x104, … and no trigger, then drop CAP_EN. Required: DONE, COUNT=8, OVERFLOW=1, drain yields PC 0x10C..0x128 in order, then IDLE.
- Pulse TRIG with the 3rd write, then write 5 more. Required: DONE after the 5th entry total, COUNT=5, the 6th–8th writes ignored.
- TRIG_PC_EN=1, TRIG_PC=0x200, retire PCs 0x1F8, 0x1FC, 0x200 with idle gaps, then 0x204, 0x208. Required: DONE after 0x208, COUNT=5.
- STOP_FULL=1, 8 writes. Required: DONE on the 8th write, OVERFLOW=0. Hold RD_READY low for 3 cycles: RD_VALID stays 1 and RD_PC is stable.
- CLR asserted together with RD_READY during a drain. Required: next cycle IDLE, COUNT=0, RD_VALID=0.
- Drop RSTn asynchronously mid-POST. Required: outputs at reset values before the next CLK edge.
